// File: rtl/hsi_clk_en_sched_pkg.sv
// Shared widths, reset factors and encodings for the HSI clock-enable scheduler.
package hsi_clk_pkg;

    localparam int TX_W = 9;
    localparam int RX_W = 6;

    localparam logic [TX_W-1:0] TX_DIV_DEF = 9'd399;
    localparam logic [RX_W-1:0] RX_DIV_DEF = 6'd49;

    localparam logic CH_TX = 1'b0;
    localparam logic CH_RX = 1'b1;

    typedef enum logic [1:0] {
        STOP = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } chan_state_t;

    // An RX request is only legal when the factor fits in the RX counter.
    function automatic logic rx_div_illegal(input logic sel, input logic [TX_W-1:0] div);
        return (sel == CH_RX) && (div[TX_W-1:RX_W] != '0);
    endfunction

endpackage

// File: rtl/hsi_clk_en_sched_if.sv
// Req/ack configuration port: the requester holds cfg_wr until cfg_ack pulses.
interface hsi_clk_en_sched_if;
    import hsi_clk_pkg::*;

    logic            cfg_wr;
    logic            cfg_sel;
    logic [TX_W-1:0] cfg_div;
    logic            cfg_ack;
    logic            cfg_err;

    modport master (
        output cfg_wr,
        output cfg_sel,
        output cfg_div,
        input  cfg_ack,
        input  cfg_err
    );

    modport slave (
        input  cfg_wr,
        input  cfg_sel,
        input  cfg_div,
        output cfg_ack,
        output cfg_err
    );

endinterface

// File: rtl/hsi_clk_en_sched_div_chan.sv
// One divider channel: counter, active and shadow factor, STOP/RUN/PEND FSM and
// the mid-bit resync load.
module hsi_div_chan
    import hsi_clk_pkg::*;
#(
    parameter int           W       = 8,
    parameter logic [W-1:0] DEFAULT = '0
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         run,
    input  logic         resync,
    input  logic         ld,
    input  logic [W-1:0] ld_div,
    output logic         en,
    output logic         upd_pend
);

    chan_state_t  state;
    logic [W-1:0] cnt;
    logic [W-1:0] div;
    logic [W-1:0] shd;
    logic [W-1:0] d_eff;

    assign en    = run && (cnt == div);
    assign d_eff = (state == PEND) ? shd : div;

    // The first edge with run high only leaves STOP, so the first strobe lands
    // div cycles after the edge that sampled run. Resync takes priority over
    // the terminal-count clear and also flushes any pending factor.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= STOP;
            cnt      <= '0;
            div      <= DEFAULT;
            shd      <= DEFAULT;
            upd_pend <= 1'b0;
        end else if (!run) begin
            cnt      <= '0;
            state    <= STOP;
            upd_pend <= 1'b0;
            if (ld) begin
                div <= ld_div;
            end else if (state == PEND) begin
                div <= shd;
            end
        end else begin
            if (resync) begin
                cnt <= d_eff >> 1;
            end else if (state == STOP || en) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end

            case (state)
                STOP: begin
                    state <= RUN;
                    if (ld) begin
                        div <= ld_div;
                    end
                end
                RUN: begin
                    if (ld) begin
                        shd      <= ld_div;
                        state    <= PEND;
                        upd_pend <= 1'b1;
                    end
                end
                PEND: begin
                    if (en || resync) begin
                        div      <= shd;
                        state    <= RUN;
                        upd_pend <= 1'b0;
                    end
                end
                default: begin
                    state    <= STOP;
                    upd_pend <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/hsi_clk_en_sched.sv
// HSI clock-enable scheduler: TX and RX divider channels sharing one
// configuration port with accept, stall and reject handling.
module hsi_clk_en_sched
    import hsi_clk_pkg::*;
#(
    parameter logic [TX_W-1:0] TX_DIV_DEFAULT = TX_DIV_DEF,
    parameter logic [RX_W-1:0] RX_DIV_DEFAULT = RX_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 tx_run,
    input  logic                 rx_run,
    input  logic                 rx_resync,
    hsi_clk_en_sched_if.slave    cfg,
    output logic                 tx_upd_pend,
    output logic                 rx_upd_pend,
    output logic                 tx_clk_en,
    output logic                 rx_clk_en
);

    logic reject;
    logic tgt_pend;
    logic accept;
    logic tx_ld;
    logic rx_ld;

    // A request is looked at only on the cycle after a non-ack cycle, and
    // stalls while its target channel still holds an unapplied factor.
    always_comb begin
        reject   = rx_div_illegal(cfg.cfg_sel, cfg.cfg_div);
        tgt_pend = (cfg.cfg_sel == CH_RX) ? rx_upd_pend : tx_upd_pend;
        accept   = cfg.cfg_wr && !cfg.cfg_ack && !tgt_pend;
        tx_ld    = accept && (cfg.cfg_sel == CH_TX);
        rx_ld    = accept && (cfg.cfg_sel == CH_RX) && !reject;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cfg.cfg_ack <= 1'b0;
            cfg.cfg_err <= 1'b0;
        end else begin
            cfg.cfg_ack <= accept;
            cfg.cfg_err <= accept && reject;
        end
    end

    hsi_div_chan #(
        .W       (TX_W),
        .DEFAULT (TX_DIV_DEFAULT)
    ) u_tx (
        .clk      (clk),
        .n_rst    (n_rst),
        .run      (tx_run),
        .resync   (1'b0),
        .ld       (tx_ld),
        .ld_div   (cfg.cfg_div),
        .en       (tx_clk_en),
        .upd_pend (tx_upd_pend)
    );

    hsi_div_chan #(
        .W       (RX_W),
        .DEFAULT (RX_DIV_DEFAULT)
    ) u_rx (
        .clk      (clk),
        .n_rst    (n_rst),
        .run      (rx_run),
        .resync   (rx_resync),
        .ld       (rx_ld),
        .ld_div   (cfg.cfg_div[RX_W-1:0]),
        .en       (rx_clk_en),
        .upd_pend (rx_upd_pend)
    );

endmodule

// File: tb/tb_hsi_clk_en_sched.sv
// Directed bench for hsi_clk_en_sched: strobe periods, config handshake,
// stall/reject, resync and reset, with hand-computed expectations.
module tb_hsi_clk_en_sched;
    import hsi_clk_pkg::*;

    logic clk = 1'b0;
    logic n_rst;
    logic tx_run;
    logic rx_run;
    logic rx_resync;
    logic tx_upd_pend;
    logic rx_upd_pend;
    logic tx_clk_en;
    logic rx_clk_en;

    int vectors     = 0;
    int miscompares = 0;
    int n;

    hsi_clk_en_sched_if cfg_bus();

    hsi_clk_en_sched dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .tx_run      (tx_run),
        .rx_run      (rx_run),
        .rx_resync   (rx_resync),
        .cfg         (cfg_bus.slave),
        .tx_upd_pend (tx_upd_pend),
        .rx_upd_pend (rx_upd_pend),
        .tx_clk_en   (tx_clk_en),
        .rx_clk_en   (rx_clk_en)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Ticks until the selected signal is seen high; -1 if the budget runs out.
    task automatic wait_strobe(input int which, input int budget, output int count);
        count = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if ((which == 0 && tx_clk_en) || (which == 1 && rx_clk_en) ||
                (which == 2 && cfg_bus.cfg_ack)) begin
                count = i;
                break;
            end
        end
    endtask

    function automatic logic [15:0] all_outs();
        return {10'd0, tx_clk_en, rx_clk_en, cfg_bus.cfg_ack, cfg_bus.cfg_err,
                tx_upd_pend, rx_upd_pend};
    endfunction

    task automatic apply_stimulus(input logic wr, input logic sel, input logic [TX_W-1:0] div);
        cfg_bus.cfg_wr  = wr;
        cfg_bus.cfg_sel = sel;
        cfg_bus.cfg_div = div;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_rst     = 1'b0;
        tx_run    = 1'b0;
        rx_run    = 1'b0;
        rx_resync = 1'b0;
        apply_stimulus(1'b0, CH_TX, 9'd0);
        repeat (3) tick();
        check_output("reset_outputs", all_outs(), 16'd0);

        n_rst = 1'b1;
        tick();
        check_output("idle_after_reset", all_outs(), 16'd0);

        // Default periods
        tx_run = 1'b1;
        rx_run = 1'b1;
        wait_strobe(0, 500, n);
        check_output("tx_first_strobe", 16'(n), 16'd400);
        wait_strobe(0, 500, n);
        check_output("tx_period_default", 16'(n), 16'd400);
        wait_strobe(1, 100, n);
        wait_strobe(1, 100, n);
        check_output("rx_period_default", 16'(n), 16'd50);

        // TX update while running, written at cnt = 100
        wait_strobe(0, 500, n);
        tick();
        check_output("tx_strobe_width", {15'd0, tx_clk_en}, 16'd0);
        repeat (100) tick();
        apply_stimulus(1'b1, CH_TX, 9'd9);
        tick();
        check_output("tx_accept", {13'd0, cfg_bus.cfg_ack, cfg_bus.cfg_err, tx_upd_pend}, 16'b101);
        apply_stimulus(1'b0, CH_TX, 9'd9);
        tick();
        check_output("ack_one_cycle", {15'd0, cfg_bus.cfg_ack}, 16'd0);
        wait_strobe(0, 400, n);
        check_output("tx_old_period_completes", 16'(n), 16'd297);
        check_output("tx_pend_until_boundary", {15'd0, tx_upd_pend}, 16'd1);
        tick();
        check_output("tx_pend_cleared", {15'd0, tx_upd_pend}, 16'd0);
        wait_strobe(0, 50, n);
        check_output("tx_new_first", 16'(n), 16'd9);
        wait_strobe(0, 50, n);
        check_output("tx_new_period", 16'(n), 16'd10);

        // Second write stalls while the first is pending
        tick();
        apply_stimulus(1'b1, CH_TX, 9'd4);
        tick();
        check_output("tx_second_accept", {14'd0, cfg_bus.cfg_ack, tx_upd_pend}, 16'b11);
        apply_stimulus(1'b0, CH_TX, 9'd4);
        tick();
        apply_stimulus(1'b1, CH_TX, 9'd6);
        tick();
        check_output("stall_no_ack", {15'd0, cfg_bus.cfg_ack}, 16'd0);
        wait_strobe(2, 50, n);
        check_output("stalled_ack_latency", 16'(n), 16'd8);
        check_output("third_pend", {15'd0, tx_upd_pend}, 16'd1);
        apply_stimulus(1'b0, CH_TX, 9'd6);
        wait_strobe(0, 50, n);
        check_output("tx_div4_boundary", 16'(n), 16'd3);
        wait_strobe(0, 50, n);
        check_output("tx_div6_first", 16'(n), 16'd7);
        wait_strobe(0, 50, n);
        check_output("tx_div6_period", 16'(n), 16'd7);

        // Illegal RX factor is rejected
        apply_stimulus(1'b1, CH_RX, 9'd64);
        tick();
        check_output("rx_reject", {13'd0, cfg_bus.cfg_ack, cfg_bus.cfg_err, rx_upd_pend}, 16'b110);
        apply_stimulus(1'b0, CH_RX, 9'd64);
        tick();
        check_output("err_one_cycle", {14'd0, cfg_bus.cfg_ack, cfg_bus.cfg_err}, 16'd0);
        wait_strobe(1, 100, n);
        wait_strobe(1, 100, n);
        check_output("rx_period_after_reject", 16'(n), 16'd50);

        // Resync mid-period and on the terminal cycle
        tick();
        repeat (10) tick();
        rx_resync = 1'b1;
        tick();
        rx_resync = 1'b0;
        wait_strobe(1, 100, n);
        check_output("rx_resync_mid", 16'(n), 16'd25);
        rx_resync = 1'b1;
        check_output("rx_strobe_with_resync", {15'd0, rx_clk_en}, 16'd1);
        tick();
        rx_resync = 1'b0;
        wait_strobe(1, 100, n);
        check_output("rx_resync_terminal", 16'(n), 16'd25);

        // Resync flushes a pending RX factor and uses it for the mid-bit load
        tick();
        repeat (5) tick();
        apply_stimulus(1'b1, CH_RX, 9'd19);
        tick();
        check_output("rx_pend_set", {14'd0, cfg_bus.cfg_ack, rx_upd_pend}, 16'b11);
        apply_stimulus(1'b0, CH_RX, 9'd19);
        rx_resync = 1'b1;
        tick();
        rx_resync = 1'b0;
        check_output("rx_pend_flushed", {15'd0, rx_upd_pend}, 16'd0);
        wait_strobe(1, 100, n);
        check_output("rx_resync_pending", 16'(n), 16'd10);
        wait_strobe(1, 100, n);
        check_output("rx_div19_period", 16'(n), 16'd20);

        // Reset with an RX update pending and a TX request held across it
        tick();
        apply_stimulus(1'b1, CH_RX, 9'd30);
        tick();
        apply_stimulus(1'b0, CH_RX, 9'd30);
        check_output("rx_pend_before_reset", {15'd0, rx_upd_pend}, 16'd1);
        apply_stimulus(1'b1, CH_TX, 9'd0);
        n_rst  = 1'b0;
        tx_run = 1'b0;
        rx_run = 1'b0;
        #1;
        check_output("reset_mid_period", all_outs(), 16'd0);
        tick();
        tick();
        check_output("reset_held_wr", all_outs(), 16'd0);
        n_rst = 1'b1;
        tick();
        check_output("held_wr_after_release", {12'd0, cfg_bus.cfg_ack, cfg_bus.cfg_err,
                     tx_upd_pend, rx_upd_pend}, 16'b1000);
        apply_stimulus(1'b0, CH_TX, 9'd0);
        tx_run = 1'b1;
        rx_run = 1'b1;
        tick();
        check_output("tx_div0_strobe_a", {15'd0, tx_clk_en}, 16'd1);
        tick();
        check_output("tx_div0_strobe_b", {15'd0, tx_clk_en}, 16'd1);
        wait_strobe(1, 100, n);
        check_output("rx_default_after_reset", 16'(n), 16'd48);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hsi_clk_en_sched.md
# hsi_clk_en_sched

Runtime-programmable clock-enable scheduler for the HSI master. Generates the `tx_clk_en` and `rx_clk_en` strobes that pace the serial transmitter and receiver. Each channel is started and stopped independently. Divide factors are reconfigured through a req/ack port, and the new factor takes effect only at a period boundary. The receive enable can be re-phased onto a detected start-bit edge.

## Interface
- `TX_W`, 9: TX divide-factor width.
- `RX_W`, 6: RX divide-factor width.
- `TX_DIV_DEFAULT`, 9'd399: TX factor loaded at reset.
- `RX_DIV_DEFAULT`, 6'd49: RX factor loaded at reset.
- `clk` input 1: single clock.
- `n_rst` input 1: reset, asynchronous, active-low.
- `tx_run` input 1: TX channel enable (level).
- `rx_run` input 1: RX channel enable (level).
- `rx_resync` input 1: one-cycle pulse; re-phase the RX counter to mid-bit.
- `cfg_wr` input 1: config request; held until `cfg_ack`.
- `cfg_sel` input 1: target channel; 0 = TX, 1 = RX.
- `cfg_div` input TX_W: requested divide factor.
- `cfg_ack` output 1: one-cycle accept pulse.
- `cfg_err` output 1: one-cycle pulse, coincident with `cfg_ack`, when the request is rejected.
- `tx_upd_pend` output 1: TX update waiting for a boundary.
- `rx_upd_pend` output 1: RX update waiting for a boundary.
- `tx_clk_en` output 1: TX strobe.
- `rx_clk_en` output 1: RX strobe.

## Operation
- **Per channel:** counter `cnt`, active factor `div`, shadow factor `shd`, 3-state FSM `STOP` / `RUN` / `PEND`.
- **Strobe:**
  - `en = run && cnt == div`, combinational from registers and `run`.
  - When `en` is high, `cnt` clears to 0; otherwise `cnt` increments while `run` is high.
  - Period is `div+1` cycles; `div = 0` gives `en` every cycle.
- **Stopping:** `run = 0` forces `cnt` to 0 on the next edge and `en` low immediately. FSM goes to `STOP`; a pending shadow is applied on that edge.
- **Config accept:**
  - Evaluated only when `cfg_wr` is high and `cfg_ack` was low in the previous cycle.
  - The target channel must not be in `PEND`; otherwise the request stalls (no ack) until the pending update is applied.
  - On accept, `cfg_ack` pulses on the next cycle.
- **Reject:** `cfg_sel = 1` with `cfg_div[TX_W-1:RX_W] != 0`. Result is `cfg_ack` + `cfg_err`, no state change.
- **Apply, channel in `STOP`:** `div <= cfg_div` at the accept edge.
- **Apply, channel in `RUN`:** `shd <= cfg_div`, FSM goes to `PEND`, `upd_pend = 1`. At the first edge where `en = 1` (or on `rx_resync` / `run` falling): `div <= shd`, `cnt <= 0`, FSM returns to `RUN`, `upd_pend = 0`.
- **Resync (RX only, ignored when `rx_run = 0`):**
  - `cnt <= d >> 1`, where `d` is `shd` if the channel is in `PEND`, else `div`. Any pending update is applied on the same edge.
  - Resync wins over the terminal-count clear. `rx_clk_en` is still asserted in a coincident terminal cycle.
- **Reset:** `tx_clk_en`, `rx_clk_en`, `cfg_ack`, `cfg_err`, `tx_upd_pend`, `rx_upd_pend` are all 0. `cnt` = 0, `div` = default, FSM = `STOP`. Reset mid-period or with an update pending discards all state; a held `cfg_wr` is re-evaluated after release.

## Timing
- `run` sampled high at edge 0 → `en` high in cycle `div` after that edge, then every `div+1` cycles.
- `cfg_wr` rising at edge k (eligible) → `cfg_ack` high cycle k+1 → `cfg_wr` may drop at edge k+1.
- Requester must deassert `cfg_wr` after `cfg_ack`, or start a new request.
- **Update in `RUN`:** the current period completes with the old `div`, and the next period uses the new one. No period is ever shorter than `min(old, new) + 1`.
- **Resync:**
  - `rx_resync` sampled at edge r → `cnt = d >> 1` in cycle r+1.
  - Next `rx_clk_en` at cycle r+1+(d − (d >> 1)).
- **TX/RX independence:** the channels never interact except through the shared config port.

## Structure
- **Package `hsi_clk_pkg`:**
  - Width constants `TX_W` and `RX_W`.
  - Default factors.
  - `CH_TX` / `CH_RX` select encodings.
  - FSM state encoding `STOP` / `RUN` / `PEND`.
- **Sub-module `hsi_div_chan`:**
  - Parameterised by width and default factor.
  - Contains the counter, active/shadow registers, FSM and resync load.
  - Instantiated twice: TX has resync tied low.
- **Top level:** config accept/stall/reject logic and the ack/err pulse registers.

## Test plan
- Reset release, `tx_run = 1`, defaults → first `tx_clk_en` at cycle 399, then period 400. `rx_clk_en` period 50 with `rx_run = 1`.
- TX running, write `cfg_div = 9` at cnt = 100 → `cfg_ack` next cycle and `tx_upd_pend = 1` until cycle 399. Then period 10, `tx_upd_pend = 0`.
- Second TX write while pending → no `cfg_ack` until boundary. Ack one cycle after the pending update applies, and the second value is used from the following boundary.
- RX write `cfg_div = 9'd64` → `cfg_ack` + `cfg_err`, RX period unchanged at 50.
- `rx_div = 49`, `rx_resync` at arbitrary cnt → `cnt = 24` next cycle, `rx_clk_en` 25 cycles later. Resync coincident with terminal count → strobe still asserted, counter loaded to 24.
- `n_rst` low mid-period with RX update pending → all outputs 0 within reset. After release: defaults, no pending, `STOP` until `run`.
